// File: rtl/bit_scan_arbiter.sv
// Arbitrated serial bit-scan engine: grants one requester, scans its vector LSB first,
// reports ones count and lowest set index. Define BIT_SCAN_FIXED_PRIORITY_EN for fixed priority.
module bit_scan_arbiter #(
    parameter int WIDTH = 10,
    parameter int NREQ  = 4,
    localparam int IDXW = $clog2(WIDTH),
    localparam int CNTW = $clog2(WIDTH + 1),
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_vec,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [IDXW-1:0]       cur_index,
    output logic                  cur_bit,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [CNTW-1:0]       res_ones,
    output logic                  res_found,
    output logic [IDXW-1:0]       res_first
);

    // Result handshake: res_* are stable while res_valid is high; a result is
    // consumed on a rising edge where res_valid and res_ready are both high.
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t           state;
    logic [WIDTH-1:0] cap_vec;
    logic             any_req;
    logic [IDW-1:0]   win_id;
    logic [NREQ-1:0]  win_onehot;
    logic [WIDTH-1:0] win_vec;

`ifdef BIT_SCAN_FIXED_PRIORITY_EN
    always_comb begin
        win_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] rr_ptr;
    logic [IDW:0]   pos;

    // Walk offsets from the far end down so the smallest offset from rr_ptr wins.
    always_comb begin
        win_id = '0;
        pos    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && pos == (IDW+1)'(i)) win_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == REPORT && res_ready) begin
            rr_ptr <= (res_id == IDW'(NREQ - 1)) ? '0 : res_id + IDW'(1);
        end
    end
`endif

    always_comb begin
        any_req    = |req;
        win_vec    = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_vec       = req_vec[i*WIDTH +: WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign cur_bit = cap_vec[cur_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            cap_vec   <= '0;
            cur_index <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_ones  <= '0;
            res_found <= 1'b0;
            res_first <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= SCAN;
                        gnt       <= win_onehot;
                        busy      <= 1'b1;
                        cap_vec   <= win_vec;
                        res_id    <= win_id;
                        res_ones  <= '0;
                        res_found <= 1'b0;
                        res_first <= '0;
                        cur_index <= '0;
                    end
                end
                SCAN: begin
                    if (cap_vec[cur_index]) begin
                        res_ones <= res_ones + CNTW'(1);
                        if (!res_found) begin
                            res_found <= 1'b1;
                            res_first <= cur_index;
                        end
                    end
                    if (cur_index == IDXW'(WIDTH - 1)) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                    end else begin
                        cur_index <= cur_index + IDXW'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan_arbiter.sv
// Directed bench for bit_scan_arbiter: drivers push expected grants/results into
// queues, a negedge monitor pops and compares them.
module tb_bit_scan_arbiter;

    localparam int WIDTH = 10;
    localparam int NREQ  = 4;
    localparam int IDXW  = $clog2(WIDTH);
    localparam int CNTW  = $clog2(WIDTH + 1);
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW    = IDW + CNTW + 1 + IDXW;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_vec;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [IDXW-1:0]       cur_index;
    logic                  cur_bit;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [CNTW-1:0]       res_ones;
    logic                  res_found;
    logic [IDXW-1:0]       res_first;

    logic [PW-1:0] exp_q[$];
    int            exp_gnt_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            gnt_cyc = 0;
    int            mon_g;
    logic [PW-1:0] mon_e;

    bit_scan_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_vec(req_vec), .gnt(gnt), .busy(busy),
        .cur_index(cur_index), .cur_bit(cur_bit), .res_valid(res_valid),
        .res_ready(res_ready), .res_id(res_id), .res_ones(res_ones),
        .res_found(res_found), .res_first(res_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [PW-1:0] mk(input int id, input int ones, input int found, input int first);
        return {IDW'(id), CNTW'(ones), 1'(found), IDXW'(first)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_gnt"}, 32'(gnt), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_cur_index"}, 32'(cur_index), 0);
        check({pfx, "_cur_bit"}, 32'(cur_bit), 0);
        check({pfx, "_res_valid"}, 32'(res_valid), 0);
        check({pfx, "_res_id"}, 32'(res_id), 0);
        check({pfx, "_res_ones"}, 32'(res_ones), 0);
        check({pfx, "_res_found"}, 32'(res_found), 0);
        check({pfx, "_res_first"}, 32'(res_first), 0);
    endtask

    // Monitor: every grant pulse and every accepted result is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != '0) begin
                gnt_cyc = cyc;
                if (exp_gnt_q.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 0);
                end else begin
                    mon_g = exp_gnt_q.pop_front();
                    check("gnt", 32'(gnt), 32'(1) << mon_g);
                end
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 32'(res_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", 32'({res_id, res_ones, res_found, res_first}), 32'(mon_e));
                end
            end
        end
    end

    task automatic wait_gnt(input int id);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (gnt[id]) seen = 1;
        end
        check("gnt_wait", 32'(seen), 1);
        @(posedge clk);
        #1;
        req[id] = 1'b0;
    endtask

    task automatic request(input int id, input logic [WIDTH-1:0] vec,
                           input logic [PW-1:0] exp_res, input bit push_res);
        @(posedge clk);
        #1;
        exp_gnt_q.push_back(id);
        if (push_res) exp_q.push_back(exp_res);
        req_vec[id*WIDTH +: WIDTH] = vec;
        req[id] = 1'b1;
        wait_gnt(id);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && exp_gnt_q.size() == 0) done = 1;
            else @(negedge clk);
        end
        check("drain", 32'(done), 1);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        bit seen;
        int prev;
        int k;
        rst = 1'b1;
        req = '0;
        req_vec = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request, latency and one-cycle res_valid with ready held high.
        res_ready = 1'b1;
        request(0, 10'b0000100100, mk(0, 2, 1, 2), 1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        check("res_valid_seen", 32'(seen), 1);
        check("res_valid_latency", 32'(cyc - gnt_cyc), WIDTH);
        @(negedge clk);
        check("res_valid_one_cycle", 32'(res_valid), 0);
        drain();

        // All zeros, all ones, MSB only.
        request(1, 10'h000, mk(1, 0, 0, 0), 1);
        drain();
        request(2, 10'h3FF, mk(2, 10, 1, 0), 1);
        drain();
        request(3, 10'h200, mk(3, 1, 1, 9), 1);
        drain();

        // All four requesting continuously.
        @(posedge clk);
        #1;
        req_vec = {10'h3FF, 10'h000, 10'b0101100000, 10'b0000100100};
`ifdef BIT_SCAN_FIXED_PRIORITY_EN
        for (int g = 0; g < 5; g++) begin
            exp_gnt_q.push_back(0);
            exp_q.push_back(mk(0, 2, 1, 2));
        end
`else
        exp_gnt_q.push_back(0); exp_q.push_back(mk(0, 2, 1, 2));
        exp_gnt_q.push_back(1); exp_q.push_back(mk(1, 3, 1, 5));
        exp_gnt_q.push_back(2); exp_q.push_back(mk(2, 0, 0, 0));
        exp_gnt_q.push_back(3); exp_q.push_back(mk(3, 10, 1, 0));
        exp_gnt_q.push_back(0); exp_q.push_back(mk(0, 2, 1, 2));
`endif
        req = 4'hF;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (gnt != '0) seen = 1;
            end
            check("rr_gnt_seen", 32'(seen), 1);
            if (g > 0) check("rr_gap", 32'(cyc - prev), WIDTH + 2);
            prev = cyc;
        end
        @(posedge clk);
        #1;
        req = '0;
        drain();

        // Backpressure with a pending request.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        request(1, 10'b0101100000, mk(1, 3, 1, 5), 1);
        req_vec[2*WIDTH +: WIDTH] = 10'h3FF;
        exp_gnt_q.push_back(2);
        exp_q.push_back(mk(2, 10, 1, 0));
        req[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        check("bp_valid_seen", 32'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(res_valid), 1);
            check("bp_res", 32'({res_id, res_ones, res_found, res_first}), 32'(mk(1, 3, 1, 5)));
            check("bp_no_gnt", 32'(gnt), 0);
            check("bp_busy", 32'(busy), 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        k = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (gnt[2]) seen = 1;
        end
        check("bp_gnt_after_accept", 32'(k), 3);
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        drain();

        // Reset in the middle of a scan.
        request(0, 10'h3FF, mk(0, 0, 0, 0), 0);
        req_vec[0 +: WIDTH] = 10'b0000100100;
        req_vec[2*WIDTH +: WIDTH] = 10'h000;
        req = 4'b0101;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cur_index == IDXW'(4)) seen = 1;
        end
        check("mid_scan_reached", 32'(seen), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_gnt_q.push_back(0); exp_q.push_back(mk(0, 2, 1, 2));
        exp_gnt_q.push_back(2); exp_q.push_back(mk(2, 0, 0, 0));
        repeat (2) begin
            @(negedge clk);
            check("in_rst_gnt", 32'(gnt), 0);
            check("in_rst_valid", 32'(res_valid), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_gnt(0);
        wait_gnt(2);
        drain();
        check("busy_final", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_scan_arbiter.md
# bit_scan_arbiter

Shared bit-scan engine with request arbitration. Up to NREQ requesters each present a WIDTH-bit vector; the block grants one at a time, scans the captured vector one bit per clock (LSB first), and returns a ones count and the lowest set-bit index tagged with the requester ID. It sits between several client blocks and a single serial bit-checking datapath, sequencing the datapath so that only one scan is in flight.

## Interface
- WIDTH, default 10: bits per vector, minimum 2.
- NREQ, default 4: number of requesters, minimum 1.
- Derived widths: IDXW = $clog2(WIDTH); CNTW = $clog2(WIDTH+1); IDW = max(1, $clog2(NREQ)).

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_vec  in  NREQ*WIDTH  requester i's vector in slice [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant pulse, one cycle.
- busy  out  1  high in SCAN and REPORT.
- cur_index  out  IDXW  bit currently being examined.
- cur_bit  out  1  value of the captured vector at cur_index.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  IDW  requester index of the result.
- res_ones  out  CNTW  number of set bits.
- res_found  out  1  at least one bit set.
- res_first  out  IDXW  lowest set-bit index, or 0 if none.

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: select the winner with round-robin, searching upward from pointer rr_ptr and wrapping.
  - Capture the winner's vector and ID.
  - Clear the ones count and the found flag.
  - Set cur_index to 0 and go to SCAN.
- SCAN, every cycle: examine bit cur_index.
  - If the bit is 1, increment the ones count.
  - If the bit is 1 and found is 0, set found and record cur_index as first.
  - If cur_index == WIDTH-1, go to REPORT; otherwise increment cur_index.
- REPORT: hold res_valid and all res_* stable until res_ready is sampled high.
  - On acceptance, set rr_ptr to (res_id+1) mod NREQ and return to IDLE.
- Requests arriving in SCAN or REPORT are not granted; they wait for IDLE.
- A req deasserted before it is granted has no effect.
- The requester must hold req_vec stable while req is high and not yet granted, and must drop req after gnt.
  - A req still high in IDLE is treated as a new request.
- res_ready while res_valid is low is ignored.
- Arithmetic:
  - res_ones saturates naturally at WIDTH; CNTW guarantees no overflow.
  - cur_index never exceeds WIDTH-1.
  - rr_ptr wraps modulo NREQ; non-power-of-two NREQ must wrap correctly.

## Timing
- Reset values: state IDLE, gnt 0, busy 0, cur_index 0, cur_bit = bit 0 of the cleared capture register (0), res_valid 0, res_id 0, res_ones 0, res_found 0, res_first 0, rr_ptr 0.
- Reset is asynchronous. Assertion mid-scan or mid-report aborts without producing a result, and no gnt is issued.
- Accept edge E0 (IDLE with req set): gnt for the winner is high for the single cycle after E0, which is the first SCAN cycle with cur_index 0.
- Scan occupies WIDTH cycles. res_valid rises WIDTH edges after E0.
- If res_ready is high on the first REPORT cycle, res_valid lasts exactly one cycle. The next grant can then occur on the edge after IDLE is re-entered.
- Minimum period from one grant to the next is WIDTH+2 cycles.
- busy is high from the cycle after E0 until the cycle after the result is accepted.
- cur_index and cur_bit are meaningful only when state is SCAN; in IDLE and REPORT they hold their last value.

## Configuration
- BIT_SCAN_FIXED_PRIORITY_EN defined: fixed priority; the lowest-numbered active req always wins, and rr_ptr is not implemented.
- Macro undefined (default): round-robin as described above.

## Test plan
- Single request: req=0001, vec0=10'b0000100100 → gnt=0001 for one cycle. After 10 scan cycles: res_valid=1, res_id=0, res_ones=2, res_found=1, res_first=2.
- All zeros and all ones:
  - vec=0 → res_ones=0, res_found=0, res_first=0.
  - vec=10'h3FF → res_ones=10, res_found=1, res_first=0.
- Round-robin with req=1111 held continuously and res_ready=1 → grants in order 0,1,2,3,0. With BIT_SCAN_FIXED_PRIORITY_EN defined, every grant goes to 0.
- Backpressure: res_ready=0 for 5 cycles in REPORT → res_valid and res_* stay constant, no gnt occurs despite pending req, and the next grant follows acceptance.
- Reset mid-scan: assert rst at cur_index=4 → all outputs return to their reset values immediately, and no res_valid appears. After release, a pending req is granted to requester 0.
- res_ready held high throughout with WIDTH=10 → res_valid high for exactly one cycle, and the next gnt arrives 12 cycles after the previous gnt.
